// File: rtl/mem_wb_pipe_if.sv
// MEM->WB stage bus: producer handshake, consumer handshake and forwarding taps.
interface mem_wb_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CTRL_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_mem_data;
  logic [ADDR_W-1:0] in_waddr;

  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_mem_data;
  logic [ADDR_W-1:0] out_waddr;

  logic              fwd_regwrite;
  logic [ADDR_W-1:0] fwd_waddr;
  logic [DATA_W-1:0] fwd_data;
  logic [1:0]        occupancy;

  // Pipe-register view.
  modport slave (
    input  in_valid, in_ctrl, in_alu_result, in_mem_data, in_waddr, out_ready,
    output in_ready, out_valid, out_ctrl, out_alu_result, out_mem_data, out_waddr,
    output fwd_regwrite, fwd_waddr, fwd_data, occupancy
  );

  // Surrounding pipeline view (MEM producer and WB consumer).
  modport master (
    output in_valid, in_ctrl, in_alu_result, in_mem_data, in_waddr, out_ready,
    input  in_ready, out_valid, out_ctrl, out_alu_result, out_mem_data, out_waddr,
    input  fwd_regwrite, fwd_waddr, fwd_data, occupancy
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// Elastic MEM->WB pipeline register: head register plus one skid entry,
// registered in_ready, synchronous flush and head-only forwarding taps.
module mem_wb_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CTRL_W = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  mem_wb_pipe_if.slave  bus
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [ADDR_W-1:0] waddr;
  } entry_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } occ_e;

  occ_e   r_occ, w_occ_d;
  logic   r_in_ready, w_in_ready_d;
  entry_t r_head, w_head_d;
  entry_t r_skid, w_skid_d;
  entry_t w_in_entry;
  logic   w_accept, w_retire;

  assign w_in_entry = '{ctrl: bus.in_ctrl, alu: bus.in_alu_result,
                        mem: bus.in_mem_data, waddr: bus.in_waddr};
  assign w_accept   = bus.in_valid & r_in_ready;
  assign w_retire   = (r_occ != StEmpty) & bus.out_ready;

  // Next occupancy and payload moves; flush overrides everything.
  always_comb begin
    w_occ_d  = r_occ;
    w_head_d = r_head;
    w_skid_d = r_skid;
    if (flush) begin
      w_occ_d = StEmpty;
    end else begin
      case (r_occ)
        StEmpty: begin
          if (w_accept) begin
            w_head_d = w_in_entry;
            w_occ_d  = StOne;
          end
        end
        StOne: begin
          if (w_accept && w_retire) begin
            w_head_d = w_in_entry;
          end else if (w_accept) begin
            w_skid_d = w_in_entry;
            w_occ_d  = StTwo;
          end else if (w_retire) begin
            w_occ_d  = StEmpty;
          end
        end
        StTwo: begin
          // in_ready is low here, so no accept can coincide.
          if (w_retire) begin
            w_head_d = r_skid;
            w_occ_d  = StOne;
          end
        end
        default: w_occ_d = StEmpty;
      endcase
    end
    w_in_ready_d = (w_occ_d != StTwo);
  end

  // State registers; reset clears payload and opens in_ready at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_occ      <= StEmpty;
      r_in_ready <= 1'b1;
      r_head     <= '0;
      r_skid     <= '0;
    end else begin
      r_occ      <= w_occ_d;
      r_in_ready <= w_in_ready_d;
      r_head     <= w_head_d;
      r_skid     <= w_skid_d;
    end
  end

  assign bus.in_ready       = r_in_ready;
  assign bus.out_valid      = (r_occ != StEmpty);
  assign bus.occupancy      = r_occ;
  assign bus.out_ctrl       = r_head.ctrl;
  assign bus.out_alu_result = r_head.alu;
  assign bus.out_mem_data   = r_head.mem;
  assign bus.out_waddr      = r_head.waddr;

  // Forwarding taps look only at the head entry, never at in_*.
  assign bus.fwd_regwrite = bus.out_valid & r_head.ctrl[0] & (r_head.waddr != '0);
  assign bus.fwd_waddr    = r_head.waddr;
  assign bus.fwd_data     = r_head.ctrl[1] ? r_head.mem : r_head.alu;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: directed scenarios plus a random run
// against a queue-based model of the two-entry stage.
module tb_mem_wb_pipe;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  always #5 clock = ~clock;

  mem_wb_pipe_if #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW)) ifc ();

  mem_wb_pipe #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (ifc)
  );

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] alu;
    logic [DW-1:0] mem;
    logic [AW-1:0] waddr;
  } ent_t;

  int   checks   = 0;
  int   failures = 0;
  ent_t mq[$];
  bit   m_ready  = 1'b1;

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] a,
                       input logic [DW-1:0] m, input logic [AW-1:0] w);
    ifc.in_valid      = v;
    ifc.in_ctrl       = c;
    ifc.in_alu_result = a;
    ifc.in_mem_data   = m;
    ifc.in_waddr      = w;
  endtask

  // One clock: model decides accept/retire from pre-edge inputs, then updates.
  task automatic cycle();
    bit   acc, ret;
    ent_t e;
    acc = (ifc.in_valid === 1'b1) && m_ready;
    ret = (mq.size() != 0) && (ifc.out_ready === 1'b1);
    e   = '{ctrl: ifc.in_ctrl, alu: ifc.in_alu_result, mem: ifc.in_mem_data,
            waddr: ifc.in_waddr};
    @(posedge clock);
    if (flush) begin
      mq.delete();
    end else begin
      if (ret) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    m_ready = (mq.size() < 2);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, '0);
    ifc.out_ready = 1'b1;
    flush         = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0, '0, '0);
    ifc.out_ready = 1'b0;
    #1 reset = 1'b1;
    #2;
    checks++;
    if ({ifc.occupancy, ifc.out_valid, ifc.in_ready, ifc.fwd_regwrite} !== 5'b00010) begin
      failures++;
      $display("FAIL reset_status: got occ/valid/ready/fwd=%b expected 00010",
               {ifc.occupancy, ifc.out_valid, ifc.in_ready, ifc.fwd_regwrite});
    end
    checks++;
    if ({ifc.out_ctrl, ifc.out_alu_result, ifc.out_mem_data, ifc.out_waddr} !== '0) begin
      failures++;
      $display("FAIL reset_payload: got alu=%h mem=%h expected 0",
               ifc.out_alu_result, ifc.out_mem_data);
    end
    #2 reset = 1'b0;
    mq.delete();
    m_ready = 1'b1;
  endtask

  task automatic test_stream();
    idle();
    drive(1'b1, 6'h01, 32'h11, 32'h0, 5'd3);
    cycle();
    checks++;
    if ({ifc.out_alu_result, ifc.fwd_data, ifc.fwd_regwrite, ifc.occupancy} !==
        {32'h11, 32'h11, 1'b1, 2'd1}) begin
      failures++;
      $display("FAIL stream_A: got alu=%h fwd=%h rw=%b occ=%0d expected 11 11 1 1",
               ifc.out_alu_result, ifc.fwd_data, ifc.fwd_regwrite, ifc.occupancy);
    end
    drive(1'b1, 6'h01, 32'h22, 32'h0, 5'd4);
    cycle();
    checks++;
    if ({ifc.out_alu_result, ifc.out_waddr, ifc.occupancy} !== {32'h22, 5'd4, 2'd1}) begin
      failures++;
      $display("FAIL stream_B: got alu=%h waddr=%0d occ=%0d expected 22 4 1",
               ifc.out_alu_result, ifc.out_waddr, ifc.occupancy);
    end
    drive(1'b1, 6'h01, 32'h33, 32'h0, 5'd5);
    cycle();
    checks++;
    if ({ifc.out_alu_result, ifc.occupancy, ifc.in_ready} !== {32'h33, 2'd1, 1'b1}) begin
      failures++;
      $display("FAIL stream_C: got alu=%h occ=%0d rdy=%b expected 33 1 1",
               ifc.out_alu_result, ifc.occupancy, ifc.in_ready);
    end
    drive(1'b0, '0, '0, '0, '0);
    cycle();
    checks++;
    if ({ifc.occupancy, ifc.out_valid, ifc.fwd_regwrite} !== 4'b0000) begin
      failures++;
      $display("FAIL stream_drain: got occ=%0d valid=%b rw=%b expected 0 0 0",
               ifc.occupancy, ifc.out_valid, ifc.fwd_regwrite);
    end
  endtask

  task automatic test_back_pressure();
    idle();
    ifc.out_ready = 1'b0;
    drive(1'b1, 6'h01, 32'hA0, 32'h0, 5'd1);
    cycle();
    drive(1'b1, 6'h01, 32'hB0, 32'h0, 5'd2);
    cycle();
    checks++;
    if ({ifc.occupancy, ifc.in_ready, ifc.out_alu_result} !== {2'd2, 1'b0, 32'hA0}) begin
      failures++;
      $display("FAIL bp_full: got occ=%0d rdy=%b alu=%h expected 2 0 a0",
               ifc.occupancy, ifc.in_ready, ifc.out_alu_result);
    end
    // Entry offered while full must be ignored.
    drive(1'b1, 6'h01, 32'hC0, 32'h0, 5'd3);
    cycle();
    checks++;
    if ({ifc.occupancy, ifc.in_ready, ifc.out_alu_result} !== {2'd2, 1'b0, 32'hA0}) begin
      failures++;
      $display("FAIL bp_hold: got occ=%0d rdy=%b alu=%h expected 2 0 a0",
               ifc.occupancy, ifc.in_ready, ifc.out_alu_result);
    end
    drive(1'b0, '0, '0, '0, '0);
    ifc.out_ready = 1'b1;
    cycle();
    checks++;
    if ({ifc.occupancy, ifc.in_ready, ifc.out_alu_result} !== {2'd1, 1'b1, 32'hB0}) begin
      failures++;
      $display("FAIL bp_first_retire: got occ=%0d rdy=%b alu=%h expected 1 1 b0",
               ifc.occupancy, ifc.in_ready, ifc.out_alu_result);
    end
    cycle();
    checks++;
    if ({ifc.occupancy, ifc.out_valid} !== 3'b000) begin
      failures++;
      $display("FAIL bp_empty: got occ=%0d valid=%b expected 0 0",
               ifc.occupancy, ifc.out_valid);
    end
  endtask

  task automatic test_load_fwd();
    idle();
    ifc.out_ready = 1'b0;
    drive(1'b1, 6'h03, 32'hDEAD, 32'hBEEF, 5'd9);
    cycle();
    checks++;
    if ({ifc.fwd_regwrite, ifc.fwd_data, ifc.fwd_waddr} !== {1'b1, 32'hBEEF, 5'd9}) begin
      failures++;
      $display("FAIL load_fwd: got rw=%b data=%h waddr=%0d expected 1 beef 9",
               ifc.fwd_regwrite, ifc.fwd_data, ifc.fwd_waddr);
    end
    ifc.out_ready = 1'b1;
    drive(1'b1, 6'h03, 32'hDEAD, 32'hBEEF, 5'd0);
    cycle();
    checks++;
    if ({ifc.fwd_regwrite, ifc.out_ctrl, ifc.out_waddr, ifc.out_valid} !==
        {1'b0, 6'h03, 5'd0, 1'b1}) begin
      failures++;
      $display("FAIL load_r0: got rw=%b ctrl=%h waddr=%0d valid=%b expected 0 03 0 1",
               ifc.fwd_regwrite, ifc.out_ctrl, ifc.out_waddr, ifc.out_valid);
    end
  endtask

  task automatic test_flush();
    idle();
    ifc.out_ready = 1'b0;
    drive(1'b1, 6'h01, 32'h51, 32'h0, 5'd1);
    cycle();
    drive(1'b1, 6'h01, 32'h52, 32'h0, 5'd2);
    cycle();
    flush = 1'b1;
    drive(1'b1, 6'h01, 32'h53, 32'h0, 5'd3);
    cycle();
    checks++;
    if ({ifc.occupancy, ifc.out_valid, ifc.in_ready, ifc.fwd_regwrite} !== 5'b00010) begin
      failures++;
      $display("FAIL flush_clear: got occ/valid/ready/fwd=%b expected 00010",
               {ifc.occupancy, ifc.out_valid, ifc.in_ready, ifc.fwd_regwrite});
    end
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    ifc.out_ready = 1'b1;
    cycle();
    checks++;
    if ({ifc.occupancy, ifc.out_valid} !== 3'b000) begin
      failures++;
      $display("FAIL flush_no_ghost: got occ=%0d valid=%b expected 0 0",
               ifc.occupancy, ifc.out_valid);
    end
  endtask

  task automatic test_async_reset();
    idle();
    ifc.out_ready = 1'b0;
    drive(1'b1, 6'h01, 32'h61, 32'h7, 5'd1);
    cycle();
    drive(1'b1, 6'h01, 32'h62, 32'h8, 5'd2);
    cycle();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ifc.occupancy, ifc.out_valid, ifc.in_ready, ifc.fwd_regwrite,
         ifc.out_alu_result, ifc.out_mem_data} !== {5'b00010, 64'h0}) begin
      failures++;
      $display("FAIL async_reset: got occ=%0d valid=%b rdy=%b alu=%h expected 0 0 1 0",
               ifc.occupancy, ifc.out_valid, ifc.in_ready, ifc.out_alu_result);
    end
    #1 reset = 1'b0;
    mq.delete();
    m_ready = 1'b1;
    ifc.out_ready = 1'b1;
    drive(1'b1, 6'h01, 32'h44, 32'h0, 5'd6);
    cycle();
    checks++;
    if ({ifc.out_valid, ifc.out_alu_result, ifc.out_waddr} !== {1'b1, 32'h44, 5'd6}) begin
      failures++;
      $display("FAIL post_reset_D: got valid=%b alu=%h waddr=%0d expected 1 44 6",
               ifc.out_valid, ifc.out_alu_result, ifc.out_waddr);
    end
  endtask

  task automatic test_hilo();
    idle();
    drive(1'b1, 6'h30, 32'h1234, 32'h0, 5'd7);
    cycle();
    checks++;
    if ({ifc.out_ctrl, ifc.fwd_regwrite, ifc.out_alu_result} !== {6'h30, 1'b0, 32'h1234}) begin
      failures++;
      $display("FAIL hilo: got ctrl=%h rw=%b alu=%h expected 30 0 1234",
               ifc.out_ctrl, ifc.fwd_regwrite, ifc.out_alu_result);
    end
  endtask

  task automatic test_random();
    ent_t h;
    logic exp_rw;
    idle();
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), CW'($urandom), $urandom, $urandom,
            AW'($urandom_range(0, 3)));
      ifc.out_ready = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 29) == 0);
      cycle();
      checks++;
      if ({ifc.occupancy, ifc.out_valid, ifc.in_ready} !==
          {2'(mq.size()), mq.size() != 0, m_ready}) begin
        failures++;
        $display("FAIL rand_status[%0d]: got occ=%0d valid=%b rdy=%b expected %0d %b %b", i,
                 ifc.occupancy, ifc.out_valid, ifc.in_ready, mq.size(), mq.size() != 0,
                 m_ready);
      end
      if (mq.size() != 0) begin
        h      = mq[0];
        exp_rw = h.ctrl[0] && (h.waddr != '0);
        checks++;
        if ({ifc.out_ctrl, ifc.out_alu_result, ifc.out_mem_data, ifc.out_waddr, ifc.fwd_regwrite,
             ifc.fwd_waddr, ifc.fwd_data} !==
            {h.ctrl, h.alu, h.mem, h.waddr, exp_rw, h.waddr, h.ctrl[1] ? h.mem : h.alu}) begin
          failures++;
          $display("FAIL rand_head[%0d]: got ctrl=%h alu=%h rw=%b fwd=%h expected %h %h %b %h",
                   i, ifc.out_ctrl, ifc.out_alu_result, ifc.fwd_regwrite, ifc.fwd_data,
                   h.ctrl, h.alu, exp_rw, h.ctrl[1] ? h.mem : h.alu);
        end
      end else begin
        checks++;
        if (ifc.fwd_regwrite !== 1'b0) begin
          failures++;
          $display("FAIL rand_fwd_empty[%0d]: got rw=%b expected 0", i, ifc.fwd_regwrite);
        end
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_load_fwd();
    test_flush();
    test_async_reset();
    test_hilo();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
